// File: rtl/lcm_pkg.sv
// Shared types and constants for the sequential LCM stage.
// Default operand width and the iteration counts of each phase.
package lcm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    localparam int LCM_WIDTH = 8;
    localparam int MUL_ITERS = LCM_WIDTH;
    localparam int DIV_ITERS = 2 * LCM_WIDTH;

endpackage

// File: rtl/lcm_seq_divider.sv
// Restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor.
// start loads and runs the first step; done marks the last step.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               done,
    output logic [2*WIDTH-1:0] quo
);

    localparam int ITERS = 2 * WIDTH;
    localparam int CW    = $clog2(ITERS + 1);

    logic               busy;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] qr;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   dvs;

    logic [2*WIDTH-1:0] src_q;
    logic [WIDTH:0]     src_r;
    logic [WIDTH-1:0]   src_d;
    logic [CW-1:0]      itr;
    logic [WIDTH:0]     sh;
    logic [WIDTH+1:0]   diff;
    logic               ge;
    logic [WIDTH:0]     rem_nxt;

    // One restoring step; on start the step works on the fresh operands.
    always_comb begin
        src_q   = start ? dividend : qr;
        src_r   = start ? '0 : rem;
        src_d   = start ? divisor : dvs;
        itr     = start ? '0 : cnt;
        sh      = {src_r[WIDTH-1:0], src_q[2*WIDTH-1]};
        diff    = {1'b0, sh} - {2'b00, src_d};
        // Partial remainder stays below the divisor, so bit WIDTH is 0.
        ge      = src_r[WIDTH] | ~diff[WIDTH+1];
        rem_nxt = ge ? diff[WIDTH:0] : sh;
        quo     = {src_q[2*WIDTH-2:0], ge};
        done    = (start | busy) & (itr == CW'(ITERS - 1));
    end

    // Iteration state: quotient/dividend shift register, remainder, count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            qr   <= '0;
            rem  <= '0;
            dvs  <= '0;
        end else if (start | busy) begin
            qr   <= quo;
            rem  <= rem_nxt;
            dvs  <= src_d;
            cnt  <= itr + CW'(1);
            busy <= ~done;
        end
    end

endmodule

// File: rtl/lcm_seq.sv
// Sequential LCM: shift-add a*b, then restoring divide by g.
// Results leave over a valid/ready handshake; inputs stall, never drop.
module lcm_seq
    import lcm_pkg::*;
#(
    parameter int WIDTH = LCM_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   g,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] lcm,
    output logic               err
);

    localparam int NMUL = WIDTH;
    localparam int CW   = $clog2(WIDTH + 1);

    state_t state, state_nxt;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   g_r;
    logic [CW-1:0]      cnt;
    logic               hold;

    logic               short_path;
    logic               mul_last;
    logic               div_start;
    logic               div_done;
    logic [2*WIDTH-1:0] div_q;

    // Handshake outputs and phase decodes.
    always_comb begin
        in_ready   = (state == IDLE);
        out_valid  = (state == DONE) & ~hold;
        short_path = (a == '0) | (b == '0) | (g == '0);
        mul_last   = (cnt == CW'(NMUL - 1));
        div_start  = (state == DIV) & (cnt == '0);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = short_path ? DONE : MUL;
            MUL:  if (mul_last) state_nxt = DIV;
            DIV:  if (div_done) state_nxt = DONE;
            DONE: if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add multiply, result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            prod   <= '0;
            mplier <= '0;
            g_r    <= '0;
            cnt    <= '0;
            hold   <= 1'b0;
            lcm    <= '0;
            err    <= 1'b0;
        end else begin
            hold <= 1'b0;
            unique case (state)
                IDLE: if (in_valid) begin
                    mcand  <= {{WIDTH{1'b0}}, a};
                    mplier <= b;
                    g_r    <= g;
                    prod   <= '0;
                    cnt    <= '0;
                    if (short_path) begin
                        // Present short-circuit results one cycle later.
                        lcm  <= '0;
                        err  <= (a != '0) && (b != '0);
                        hold <= 1'b1;
                    end
                end
                MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= mul_last ? '0 : cnt + CW'(1);
                end
                DIV: begin
                    cnt <= CW'(1);
                    if (div_done) begin
                        lcm <= div_q;
                        err <= 1'b0;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    seq_divider #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (prod),
        .divisor  (g_r),
        .done     (div_done),
        .quo      (div_q)
    );

endmodule

// File: doc/lcm_seq.md
# lcm_seq

Sequential least-common-multiple stage placed directly downstream of the combinational `GCD` block. It takes each operand pair `a`, `b` together with the `GCD` output `g` for that pair. It computes `lcm = (a*b)/g` with a multicycle shift-add multiplier followed by a restoring divider. Results are returned over a valid/ready handshake, so `GCD` results can be consumed by a registered pipeline without a wide combinational divider.

## Interface
- `WIDTH`, 8, operand width; must match `GCD` operand width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand triple present.
- `in_ready`  out  1  block can accept a triple; high only in IDLE.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `g`  in  WIDTH  gcd(a,b) as produced by `GCD`.
- `out_valid`  out  1  result present; held until consumed.
- `out_ready`  in  1  consumer accepts the result.
- `lcm`  out  2*WIDTH  result, unsigned.
- `err`  out  1  divide-by-zero flag, valid with `out_valid`.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, register `a`, `b`, `g`.
  - If `a==0` or `b==0`: `lcm`=0, `err`=0, go to DONE.
  - Else if `g==0`: `lcm`=0, `err`=1, go to DONE.
  - Else go to MUL.
- MUL:
  - WIDTH iterations of shift-add: if multiplier LSB is 1, add the multiplicand to the 2*WIDTH-bit product accumulator; then shift.
  - The product is exact and cannot overflow 2*WIDTH bits.
- DIV:
  - 2*WIDTH iterations of restoring division of the product by zero-extended `g`.
  - The remainder register is WIDTH+1 bits; the quotient is 2*WIDTH bits.
  - Quotient goes to `lcm`, remainder is discarded.
  - A `g` that does not divide `a*b` is not checked; the truncated quotient is reported.
- DONE:
  - `out_valid`=1; `lcm` and `err` are stable.
  - On `out_ready`, go to IDLE.
- `in_ready` is 0 in MUL, DIV and DONE; new triples are never dropped, only stalled.
- `lcm` and `err` hold their last value outside DONE.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `lcm`=0, `err`=0, all datapath registers 0.
- Reset is asynchronous and takes effect mid-operation from any state. An in-flight result is discarded and not emitted.
- Normal path, with acceptance at edge 0:
  - MUL occupies edges 1..WIDTH.
  - DIV occupies edges WIDTH+1..3*WIDTH.
  - `out_valid` rises after edge 3*WIDTH, i.e. 24 cycles for WIDTH=8.
- Zero or error path: `out_valid` rises after edge 1, one cycle after acceptance.
- Consumption: `out_valid && out_ready` at edge k gives `out_valid`=0 and `in_ready`=1 after edge k.
- The next accept is possible at edge k+1; there is no same-cycle pass-through.
- Minimum initiation interval is 3*WIDTH+2 cycles.
- Inputs are sampled only on the accept edge; changes at any other time are ignored.

## Structure
- Package `lcm_pkg` holds:
  - the state enum (IDLE, MUL, DIV, DONE);
  - the default WIDTH constant;
  - the iteration-count localparams MUL_ITERS=WIDTH and DIV_ITERS=2*WIDTH.
- One sub-module is natural: `seq_divider`, a 2*WIDTH by WIDTH restoring divider with start and done strobes.
- The multiplier stays inline in `lcm_seq`.

## Test plan
- Basic: `a`=15, `b`=10, `g`=5 → `lcm`=30, `err`=0; `out_valid` 24 cycles after accept.
- Coprime max-range: `a`=151, `b`=210, `g`=1 → `lcm`=31710; `a`=255, `b`=254, `g`=1 → `lcm`=64770.
- Equal operands and zero:
  - `a`=255, `b`=255, `g`=255 → `lcm`=255.
  - `a`=0, `b`=20, `g`=20 → `lcm`=0, `err`=0, `out_valid` 1 cycle after accept.
- Error: `a`=3, `b`=4, `g`=0 → `lcm`=0, `err`=1.
- Back-pressure:
  - Hold `out_ready`=0 for 10 cycles after `out_valid`; `lcm` stays stable and `in_ready` stays 0 while `in_valid` is held.
  - Release `out_ready`; the next triple (`a`=35, `b`=30, `g`=5) is accepted one cycle later and gives `lcm`=210.
- Reset mid-operation: assert `rst` during DIV of `a`=45, `b`=40, `g`=5.
  - Outputs return to reset values immediately, with no `out_valid`.
  - After release, `a`=45, `b`=40, `g`=5 gives `lcm`=360.
